// File: rtl/hash_576_word_packer.sv
// Packs 64-bit stream words into 576-bit rate blocks for the hash_576 padder; one word/cycle, +1 OFFER cycle per block.
// Backpressure: s_ready low outside FILL; block held stable while buffer_full=1.
// Optional HASH576_BYTE_SWAP_EN: byte-reverse each word so s_data[7:0] is the first message byte.
module hash_576_word_packer #(
  parameter int DATA_W  = 64,
  parameter int BLOCK_W = 576
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  input  logic [3:0]           s_bytes,
  output logic                 s_ready,
  output logic [BLOCK_W-1:0]   out_block,
  output logic                 out_ready,
  output logic                 out_last,
  output logic [9:0]           out_byte_num,
  input  logic                 buffer_full,
  output logic                 busy
);

  localparam int WORDS = BLOCK_W / DATA_W;

  typedef enum logic [1:0] {FILL, OFFER, OFFER_EMPTY, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [BLOCK_W-1:0]   blk_q, blk_d;
  logic                 last_q, last_d;
  logic                 pend_q, pend_d;
  logic [9:0]           bnum_q, bnum_d;

  logic [3:0]           nb;
  logic [DATA_W-1:0]    word;
  logic [6:0]           total;

  always_comb begin
    nb = (s_bytes == 4'd0 || s_bytes > 4'd8) ? 4'd8 : s_bytes;

`ifdef HASH576_BYTE_SWAP_EN
    for (int b = 0; b < 8; b++) begin
      word[8*b +: 8] = s_data[DATA_W-1-8*b -: 8];
    end
`else
    word = s_data;
`endif
    // Once byte order is normalised, valid bytes are always the top nb bytes.
    for (int b = 0; b < 8; b++) begin
      if (s_last && (4'(b) >= nb)) begin
        word[DATA_W-1-8*b -: 8] = 8'h00;
      end
    end

    total = {wcnt_q, 3'b000} + {3'b000, nb};

    state_d = state_q;
    wcnt_d  = wcnt_q;
    blk_d   = blk_q;
    last_d  = last_q;
    pend_d  = pend_q;
    bnum_d  = bnum_q;

    if (clear) begin
      state_d = FILL;
      wcnt_d  = 4'd0;
      blk_d   = '0;
      last_d  = 1'b0;
      pend_d  = 1'b0;
      bnum_d  = 10'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid) begin
            for (int k = 0; k < WORDS; k++) begin
              if (wcnt_q == 4'(k)) begin
                blk_d[BLOCK_W-1-DATA_W*k -: DATA_W] = word;
              end
            end
            if (s_last) begin
              state_d = OFFER;
              // An exactly full final block still owes the padder an empty last block.
              if (total == 7'(BLOCK_W/8)) begin
                last_d = 1'b0;
                pend_d = 1'b1;
                bnum_d = 10'd0;
              end else begin
                last_d = 1'b1;
                bnum_d = {3'b000, total};
              end
            end else if (wcnt_q == 4'(WORDS-1)) begin
              state_d = OFFER;
              last_d  = 1'b0;
            end else begin
              wcnt_d = wcnt_q + 4'd1;
            end
          end
        end
        OFFER: begin
          if (!buffer_full) begin
            if (last_q) begin
              state_d = DONE;
            end else if (pend_q) begin
              state_d = OFFER_EMPTY;
            end else begin
              state_d = FILL;
              wcnt_d  = 4'd0;
              blk_d   = '0;
            end
          end
        end
        OFFER_EMPTY: begin
          if (!buffer_full) begin
            state_d = DONE;
            pend_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      wcnt_q  <= 4'd0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      bnum_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      bnum_q  <= bnum_d;
    end
  end

  // Padder requires is_last/byte_num low whenever in_ready is low.
  assign s_ready      = (state_q == FILL);
  assign out_ready    = (state_q == OFFER) || (state_q == OFFER_EMPTY);
  assign out_block    = (state_q == OFFER) ? blk_q : '0;
  assign out_last     = ((state_q == OFFER) && last_q) || (state_q == OFFER_EMPTY);
  assign out_byte_num = ((state_q == OFFER) && last_q) ? bnum_q : 10'd0;
  assign busy         = (state_q != FILL) || (wcnt_q != 4'd0);

endmodule

// File: tb/tb_hash_576_word_packer.sv
// Directed bench for hash_576_word_packer; expected values are hand-computed constants.
module tb_hash_576_word_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic [63:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic [3:0]   s_bytes;
  logic         s_ready;
  logic [575:0] out_block;
  logic         out_ready;
  logic         out_last;
  logic [9:0]   out_byte_num;
  logic         buffer_full;
  logic         busy;

  int npass = 0;
  int ntot  = 0;
  logic [575:0] exp_blk;

`ifdef HASH576_BYTE_SWAP_EN
  localparam logic [63:0] W1 = 64'hEFCDAB8967452301;
  localparam logic [63:0] W2 = 64'h0DF0FECA00000000;
  localparam logic [63:0] W3 = 64'h1100FF0000000000;
  localparam logic [63:0] W4 = 64'hF0DE000000000000;
`else
  localparam logic [63:0] W1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W2 = 64'hDEADBEEF00000000;
  localparam logic [63:0] W3 = 64'hAABBCC0000000000;
  localparam logic [63:0] W4 = 64'h1234000000000000;
`endif

  hash_576_word_packer dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_bytes      (s_bytes),
    .s_ready      (s_ready),
    .out_block    (out_block),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_byte_num (out_byte_num),
    .buffer_full  (buffer_full),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic l, input logic [3:0] nb);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    s_bytes = nb;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_bytes = 4'd0;
    s_data  = 64'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clear = 1'b0; s_data = 64'd0; s_valid = 1'b0;
    s_last = 1'b0; s_bytes = 4'd0; buffer_full = 1'b0;

    #12;
    chk ("rst_s_ready",   16'(s_ready),      16'd1);
    chk ("rst_out_ready", 16'(out_ready),    16'd0);
    chk ("rst_out_last",  16'(out_last),     16'd0);
    chk ("rst_byte_num",  16'(out_byte_num), 16'd0);
    chkb("rst_block",     out_block,         576'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk ("idle_busy", 16'(busy), 16'd0);

    // single full word, last
    send(64'h0123456789ABCDEF, 1'b1, 4'd8);
    chk ("t1_out_ready", 16'(out_ready),    16'd1);
    chk ("t1_s_ready",   16'(s_ready),      16'd0);
    chkb("t1_block",     out_block,         {W1, 512'd0});
    chk ("t1_last",      16'(out_last),     16'd1);
    chk ("t1_byte_num",  16'(out_byte_num), 16'd8);
    step();
    chk ("t1_done_s_ready",   16'(s_ready),   16'd0);
    chk ("t1_done_out_ready", 16'(out_ready), 16'd0);
    chk ("t1_done_last",      16'(out_last),  16'd0);
    chk ("t1_done_busy",      16'(busy),      16'd1);

    // clear from DONE, then a partial single-word message
    do_clear();
    chk ("clr_s_ready", 16'(s_ready), 16'd1);
    chk ("clr_busy",    16'(busy),    16'd0);
    send(64'hDEADBEEFCAFEF00D, 1'b1, 4'd4);
    chkb("clr_block",    out_block,         {W2, 512'd0});
    chk ("clr_last",     16'(out_last),     16'd1);
    chk ("clr_byte_num", 16'(out_byte_num), 16'd4);
    step();
    do_clear();

    // 9 full words, then a 3-byte last word
    exp_blk = '0;
    for (int k = 0; k < 9; k++) begin
      exp_blk[575-64*k -: 64] = 64'h1111111111111111 * (k + 1);
      send(64'h1111111111111111 * (k + 1), 1'b0, 4'd0);
    end
    chk ("t2_b1_out_ready", 16'(out_ready),    16'd1);
    chk ("t2_b1_s_ready",   16'(s_ready),      16'd0);
    chkb("t2_b1_block",     out_block,         exp_blk);
    chk ("t2_b1_last",      16'(out_last),     16'd0);
    chk ("t2_b1_byte_num",  16'(out_byte_num), 16'd0);
    step();
    chk ("t2_refill_s_ready",   16'(s_ready),   16'd1);
    chk ("t2_refill_out_ready", 16'(out_ready), 16'd0);
    send(64'hAABBCCDDEEFF0011, 1'b1, 4'd3);
    chkb("t2_b2_block",    out_block,         {W3, 512'd0});
    chk ("t2_b2_last",     16'(out_last),     16'd1);
    chk ("t2_b2_byte_num", 16'(out_byte_num), 16'd3);
    step();
    do_clear();

    // exact 72-byte message with backpressure, then trailing empty block
    for (int k = 0; k < 9; k++) begin
      send(64'h1111111111111111 * (k + 1), (k == 8), 4'd8);
    end
    buffer_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chkb("t3_hold_block",     out_block,         exp_blk);
      chk ("t3_hold_last",      16'(out_last),     16'd0);
      chk ("t3_hold_byte_num",  16'(out_byte_num), 16'd0);
      chk ("t3_hold_s_ready",   16'(s_ready),      16'd0);
      chk ("t3_hold_out_ready", 16'(out_ready),    16'd1);
    end
    buffer_full = 1'b0;
    chkb("t3_xfer_block", out_block, exp_blk);
    step();
    chk ("t3_empty_out_ready", 16'(out_ready),    16'd1);
    chkb("t3_empty_block",     out_block,         576'd0);
    chk ("t3_empty_last",      16'(out_last),     16'd1);
    chk ("t3_empty_byte_num",  16'(out_byte_num), 16'd0);
    step();
    chk ("t3_done_out_ready", 16'(out_ready), 16'd0);
    chk ("t3_done_s_ready",   16'(s_ready),   16'd0);
    do_clear();

    // asynchronous reset mid-block
    for (int k = 0; k < 4; k++) begin
      send(64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0);
    end
    chk ("t4_pre_busy", 16'(busy), 16'd1);
    #2 reset = 1'b0;
    #1;
    chk ("t4_rst_busy",      16'(busy),         16'd0);
    chk ("t4_rst_out_ready", 16'(out_ready),    16'd0);
    chk ("t4_rst_s_ready",   16'(s_ready),      16'd1);
    chk ("t4_rst_last",      16'(out_last),     16'd0);
    chkb("t4_rst_block",     out_block,         576'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk ("t4_rel_s_ready",   16'(s_ready),   16'd1);
    chk ("t4_rel_out_ready", 16'(out_ready), 16'd0);
    send(64'h123456789ABCDEF0, 1'b1, 4'd2);
    chkb("t4_block",    out_block,         {W4, 512'd0});
    chk ("t4_byte_num", 16'(out_byte_num), 16'd2);
    chk ("t4_last",     16'(out_last),     16'd1);
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/hash_576_word_packer.md
Name: hash_576_word_packer

Overview:
- Upstream feeder for the 576-bit padder in the hash_576 path.
- Accepts the message as 64-bit words over a valid/ready stream and packs them into 576-bit (72-byte) rate blocks.
- Drives the padder's in / in_ready / is_last / byte_num inputs and obeys its buffer_full backpressure.
- Generates the trailing zero-length last block when the message length is an exact multiple of 72 bytes.

Parameters:
- DATA_W, 64: stream word width in bits. Fixed at 64.
- BLOCK_W, 576: rate block width in bits. Must be a multiple of DATA_W.
- WORDS, BLOCK_W/DATA_W (9): number of words per block. Derived; not overridable.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous restart for a new message.
- s_data  input  64  message word; first byte is in bits [63:56].
- s_valid  input  1  s_data is valid.
- s_last  input  1  this word ends the message.
- s_bytes  input  4  valid bytes in the last word (1..8); ignored unless s_last.
- s_ready  output  1  packer accepts a word this cycle.
- out_block  output  576  block to padder `in`; word k occupies bits [575-64k -: 64].
- out_ready  output  1  to padder `in_ready`.
- out_last  output  1  to padder `is_last`.
- out_byte_num  output  10  to padder `byte_num`.
- buffer_full  input  1  from padder; a block transfers on a cycle with out_ready & ~buffer_full.
- busy  output  1  high when state is not FILL or wcnt is not 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FILL, wcnt=0, block register=0, last_flag=0, pend_empty=0.
  - Outputs: out_ready=0, out_last=0, out_byte_num=0, out_block=0, s_ready=1.
- States: FILL, OFFER, OFFER_EMPTY, DONE.
- s_ready = (state==FILL). A word is accepted on s_valid & s_ready.
- FILL, word accepted:
  - Write s_data into slot wcnt. If s_last, zero the bytes past s_bytes.
  - s_bytes of 0 or greater than 8 is treated as 8.
  - Non-last word with wcnt=8: go to OFFER with last_flag=0. Otherwise wcnt++.
  - Last word, total bytes = 8*wcnt + s_bytes:
    - total < 72: last_flag=1, byte_num=total, go to OFFER.
    - total = 72: last_flag=0, pend_empty=1, go to OFFER.
- OFFER:
  - out_ready=1, out_block=block register, out_last=last_flag.
  - out_byte_num = byte_num if last_flag, else 0.
  - Outputs hold stable while buffer_full=1.
  - Transfer cycle, then next state:
    - last_flag=1: DONE.
    - pend_empty=1: OFFER_EMPTY.
    - otherwise: FILL, with wcnt=0 and the block register cleared.
- OFFER_EMPTY:
  - out_ready=1, out_block=0, out_last=1, out_byte_num=0.
  - On transfer, go to DONE and clear pend_empty.
- DONE: s_ready=0 and out_ready=0 until clear.
- out_last and out_byte_num are forced to 0 whenever out_ready=0. The padder requires is_last=0 when in_ready=0.
- Throughput: one word per cycle in FILL. Each block costs at least 1 extra OFFER cycle, so a 9-word block takes 10 cycles minimum.
- clear=1 in any state:
  - Returns to reset-equivalent values on the next edge.
  - Takes priority over a word accept or transfer in the same cycle.
  - The padder must be reset separately by its owner.
- Reset asserted mid-block: partial data is discarded and no block is offered.
- An empty (0-byte) message is not supported. The producer must send at least one byte.

Optional Feature:
- Macro: HASH576_BYTE_SWAP_EN.
- Defined: each accepted word is byte-reversed before placement, so s_data[7:0] is the first byte. Applies to last-word masking too: the valid bytes are the low s_bytes bytes of s_data.
- Undefined: no swap; the first byte is s_data[63:56].

Test Plan:
- One word 0x0123456789ABCDEF, s_last, s_bytes=8 -> a single OFFER:
  - out_block[575:512]=0x0123456789ABCDEF, remaining bits 0, out_last=1, out_byte_num=8.
  - Then DONE with s_ready=0.
- 9 non-last words 0x11..11 to 0x99..99, then word 0xAABBCCDDEEFF0011 with s_last, s_bytes=3:
  - Block 1: out_last=0, out_byte_num=0.
  - Block 2: out_block[575:512]=0xAABBCC0000000000, out_last=1, out_byte_num=3.
- 9 words with s_last on the 9th, s_bytes=8 -> full block with out_last=0, then an all-zero block with out_last=1, out_byte_num=0, then DONE.
- buffer_full=1 for 5 cycles while in OFFER:
  - out_block, out_last and out_byte_num stay unchanged; s_ready=0.
  - Transfer on the first cycle with buffer_full=0; state advances on the next edge.
- reset pulled low asynchronously after 4 words -> all outputs 0 immediately; s_ready=1 and out_ready=0 after release.
- clear asserted in DONE, then a new 1-word message -> accepted and offered with correct out_byte_num.
- With HASH576_BYTE_SWAP_EN: s_data 0x0123456789ABCDEF, s_bytes=8 -> out_block[575:512]=0xEFCDAB8967452301.
